// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI secondary endpoint
package spi_pkg;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_LOAD      = 2'd2;
  localparam logic [1:0] ST_SHIFT     = 2'd3;

  localparam logic [7:0] DEFAULT_UNDERRUN_FILL = 8'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-FF synchronizer with rise/fall detect on the synchronized level
module spi_sync_edge (
  input  logic CLK,
  input  logic Reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) sr <= '0;
    else        sr <= {sr[1:0], din};
  end

  // Edges compare the 2nd flop against the 3rd so they line up with dout.
  assign dout = sr[1];
  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_secondary.sv
// rtl/spi_secondary.sv - oversampled SPI secondary, full duplex, MSB first, multi-frame per select
module spi_secondary
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] UNDERRUN_FILL = DATA_WIDTH'(DEFAULT_UNDERRUN_FILL)
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [1:0]            spi_mode,
  input  logic                  cs_inv_i,
  input  logic                  CS,
  input  logic                  SCLK,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  underrun,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [1:0] mosi_sr;

  spi_sync_edge u_sclk_sync (.CLK(CLK), .Reset(Reset), .din(SCLK),
                             .dout(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge u_cs_sync   (.CLK(CLK), .Reset(Reset), .din(CS),
                             .dout(cs_lvl), .rise(cs_rise), .fall(cs_fall));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) mosi_sr <= '0;
    else        mosi_sr <= {mosi_sr[0], MOSI};
  end

  logic [1:0]            state;
  spi_mode_t             mode_q;
  logic [DATA_WIDTH-1:0] shift_reg, rx_shift, hold_reg, load_word;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  hold_full, miso_q, rx_done;
  logic                  sel, sel_rise, sel_fall, sclk_edge, lead, trail, in_shift;
  logic                  do_sample, do_drive;

  assign sel       = cs_lvl ^ ~cs_inv_i;
  assign sel_rise  = (cs_rise | cs_fall) & sel;
  assign sel_fall  = (cs_rise | cs_fall) & ~sel;
  assign sclk_edge = sclk_rise | sclk_fall;
  assign lead      = sclk_edge & (sclk_lvl ^ mode_q.cpol);
  assign trail     = sclk_edge & ~(sclk_lvl ^ mode_q.cpol);
  assign in_shift  = (state == ST_SHIFT);

  // CPHA=0 skips the trailing edge right after a reload: that load already drove the next MSB.
  assign do_sample = in_shift & (mode_q.cpha ? trail : lead);
  assign do_drive  = in_shift & (mode_q.cpha ? lead
                                 : (trail && bit_cnt != '0 && bit_cnt != CNT_FULL));

  assign load_word = hold_full ? hold_reg : UNDERRUN_FILL;
  assign tx_ready  = ~hold_full;
  assign MISO      = miso_oe ? miso_q : 1'bz;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_WAIT_IDLE;
      mode_q    <= '0;
      shift_reg <= '0;
      rx_shift  <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      miso_q    <= 1'b0;
      miso_oe   <= 1'b0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      rx_valid  <= rx_done;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
      if (rx_done) rx_data <= rx_shift;
      if (tx_valid && !hold_full) begin
        hold_reg  <= tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        ST_WAIT_IDLE: if (!sel) state <= ST_IDLE;
        ST_IDLE: begin
          miso_oe <= 1'b0;
          mode_q  <= spi_mode_t'(spi_mode);
          if (sel_rise) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (hold_full) hold_full <= 1'b0;
          else           underrun  <= 1'b1;
          miso_q    <= load_word[DATA_WIDTH-1];
          shift_reg <= mode_q.cpha ? load_word : {load_word[DATA_WIDTH-2:0], 1'b0};
          bit_cnt   <= '0;
          miso_oe   <= 1'b1;
          state     <= ST_SHIFT;
        end
        default: begin
          if (do_drive) begin
            miso_q    <= shift_reg[DATA_WIDTH-1];
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
          end
          if (do_sample) begin
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_sr[1]};
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_LAST) begin
              rx_done <= 1'b1;
              if (sel) state <= ST_LOAD;
            end
          end
        end
      endcase

      if (sel_fall) begin
        miso_oe <= 1'b0;
        state   <= ST_IDLE;
        bit_cnt <= '0;
        if (in_shift && bit_cnt != '0 && bit_cnt != CNT_FULL) frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_secondary.sv
// tb/tb_spi_secondary.sv - self-checking bench for spi_secondary acting as the SPI primary
module tb_spi_secondary;

  localparam int H = 8;

  logic       CLK_tb = 1'b0;
  logic       Reset, cs_inv_i, CS, SCLK, MOSI, tx_valid;
  logic [1:0] spi_mode;
  logic [7:0] tx_data;
  wire        miso;
  logic       miso_oe, tx_ready, rx_valid, underrun, frame_err;
  logic [7:0] rx_data;

  spi_secondary dut (
    .CLK(CLK_tb), .Reset(Reset), .spi_mode(spi_mode), .cs_inv_i(cs_inv_i),
    .CS(CS), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun), .frame_err(frame_err)
  );

  always #5 CLK_tb = ~CLK_tb;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0, ur_cnt = 0, fe_cnt = 0, oe_cnt = 0;
  logic [7:0] rx_q[$];

  always @(negedge CLK_tb) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_q.push_back(rx_data);
    end
    if (underrun)  ur_cnt++;
    if (frame_err) fe_cnt++;
    if (miso_oe)   oe_cnt++;
  end

  typedef struct {
    logic [1:0] mode;
    logic       inv;
    logic       pre;
    logic [7:0] tx_w;
    logic [7:0] mosi_w;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_ur;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] got_miso[3];
  logic [7:0] last_rx_sent;
  int         ur_snap, ur_in, ur_tot, rx_base, rx_delta;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] rxq_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK_tb);
  endtask

  task automatic tx_write(input logic [7:0] w);
    tx_data  = w;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic half(input bit wr, input logic [7:0] w);
    if (wr) begin
      chk("txrdy_mid", 32'(tx_ready), 32'd1);
      tx_write(w);
      wait_clk(H - 1);
    end else wait_clk(H);
  endtask

  task automatic sample_tail(input bit lat);
    ur_snap = ur_cnt;
    if (lat) begin
      wait_clk(3);
      chk("rxv_early", 32'(rx_valid), 32'd0);
      wait_clk(1);
      chk("rxv_lat", 32'(rx_valid), 32'd1);
      wait_clk(H - 4);
    end else wait_clk(H);
  endtask

  // Acts as the primary for one frame of nbits; returns the MISO bits it sampled.
  task automatic frame(input logic [1:0] m, input logic [7:0] w, input bit wr,
                       input logic [7:0] ww, input int nbits, input bit lat,
                       output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!m[0]) begin
        MOSI = w[i];
        half(wr && i == 4, ww);
        r[i] = miso;
        SCLK = ~m[1];
        if (i == 0) sample_tail(lat); else wait_clk(H);
        SCLK = m[1];
      end else begin
        SCLK = ~m[1];
        MOSI = w[i];
        half(wr && i == 4, ww);
        r[i] = miso;
        SCLK = m[1];
        if (i == 0) sample_tail(lat); else wait_clk(H);
      end
    end
  endtask

  task automatic set_mode(input logic [1:0] m, input logic inv);
    spi_mode = m;
    cs_inv_i = inv;
    CS       = ~inv;
    SCLK     = m[1];
    wait_clk(8);
  endtask

  task automatic run_txn(input logic [1:0] m, input logic inv, input logic pre,
                         input logic [7:0] pre_w, input int nf, input logic [2:0][7:0] mw,
                         input logic [2:0] wr, input logic [2:0][7:0] ww, input bit lat);
    int ur0, rx0;
    logic [7:0] r;
    set_mode(m, inv);
    if (pre) begin
      tx_write(pre_w);
      chk("txrdy_full", 32'(tx_ready), 32'd0);
    end
    ur0 = ur_cnt;
    rx0 = rx_cnt;
    rx_base = rx_q.size();
    CS = inv;
    wait_clk(H);
    chk("txrdy_load", 32'(tx_ready), 32'd1);
    for (int k = 0; k < nf; k++) begin
      frame(m, mw[k], wr[k], ww[k], 8, lat && k == nf - 1, r);
      got_miso[k] = r;
    end
    wait_clk(H);
    CS = ~inv;
    wait_clk(4);
    chk("oe_off", 32'(miso_oe), 32'd0);
    wait_clk(6);
    ur_in = ur_snap - ur0;
    ur_tot = ur_cnt - ur0;
    rx_delta = rx_cnt - rx0;
    last_rx_sent = mw[nf - 1];
  endtask

  logic [2:0][7:0] rmw, rww;
  logic [2:0]      rwr;
  logic [1:0]      rm;
  logic            rinv, rpre, have;
  logic [7:0]      rpw, hw, exp_w, r5;
  int              rnf, exp_ur, fe0, rx0, oe0;

  initial begin
    vecs[0] = '{2'd0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
    vecs[1] = '{2'd3, 1'b0, 1'b1, 8'h5A, 8'hC8, 8'h5A, 8'hC8, 0};
    vecs[2] = '{2'd1, 1'b0, 1'b1, 8'h96, 8'h0F, 8'h96, 8'h0F, 0};
    vecs[3] = '{2'd2, 1'b0, 1'b1, 8'h81, 8'hF0, 8'h81, 8'hF0, 0};
    vecs[4] = '{2'd0, 1'b0, 1'b0, 8'h00, 8'h02, 8'hFF, 8'h02, 1};
    vecs[5] = '{2'd2, 1'b1, 1'b1, 8'hC3, 8'h55, 8'hC3, 8'h55, 0};

    Reset = 1'b0; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0; spi_mode = 2'd0;
    cs_inv_i = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    wait_clk(3);
    chk("rst_oe", 32'(miso_oe), 32'd0);
    chk("rst_txrdy", 32'(tx_ready), 32'd1);
    chk("rst_rxd", 32'(rx_data), 32'd0);
    chk("rst_pulses", {29'd0, rx_valid, underrun, frame_err}, 32'd0);
    Reset = 1'b1;
    wait_clk(8);

    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].mode, vecs[v].inv, vecs[v].pre, vecs[v].tx_w, 1,
              {16'h0, vecs[v].mosi_w}, 3'b000, '0, 1'b1);
      chk($sformatf("tbl%0d_miso", v), 32'(got_miso[0]), 32'(vecs[v].exp_miso));
      chk($sformatf("tbl%0d_rxn", v), 32'(rx_delta), 32'd1);
      chk($sformatf("tbl%0d_rx", v), 32'(rxq_at(rx_base)), 32'(vecs[v].exp_rx));
      chk($sformatf("tbl%0d_ur", v), 32'(ur_in), 32'(vecs[v].exp_ur));
      chk($sformatf("tbl%0d_urtail", v), 32'(ur_tot), 32'(vecs[v].exp_ur + 1));
    end

    // Two frames under one select, second TX word written during the first frame.
    run_txn(2'd0, 1'b0, 1'b1, 8'h11, 2, {8'h00, 8'hD2, 8'hC1}, 3'b001, {16'h0, 8'h22}, 1'b0);
    chk("two_miso0", 32'(got_miso[0]), 32'h11);
    chk("two_miso1", 32'(got_miso[1]), 32'h22);
    chk("two_rxn", 32'(rx_delta), 32'd2);
    chk("two_rx0", 32'(rxq_at(rx_base)), 32'hC1);
    chk("two_rx1", 32'(rxq_at(rx_base + 1)), 32'hD2);

    // Select dropped after five SCLK periods.
    set_mode(2'd0, 1'b0);
    tx_write(8'h3A);
    fe0 = fe_cnt;
    rx0 = rx_cnt;
    CS = 1'b0;
    wait_clk(H);
    frame(2'd0, 8'hB4, 1'b0, 8'h00, 5, 1'b0, r5);
    CS = 1'b1;
    wait_clk(4);
    chk("ferr_oe", 32'(miso_oe), 32'd0);
    wait_clk(8);
    chk("ferr_miso", 32'(r5 & 8'hF8), 32'h38);
    chk("ferr_cnt", 32'(fe_cnt - fe0), 32'd1);
    chk("ferr_norx", 32'(rx_cnt - rx0), 32'd0);
    chk("ferr_rxd", 32'(rx_data), 32'(last_rx_sent));

    // Reset in the middle of a frame with select held active.
    set_mode(2'd0, 1'b0);
    tx_write(8'h77);
    CS = 1'b0;
    wait_clk(H);
    for (int e = 0; e < 5; e++) begin
      SCLK = ~SCLK;
      wait_clk(H);
    end
    Reset = 1'b0;
    wait_clk(1);
    chk("mrst_oe", 32'(miso_oe), 32'd0);
    chk("mrst_txrdy", 32'(tx_ready), 32'd1);
    chk("mrst_rxd", 32'(rx_data), 32'd0);
    chk("mrst_pulses", {29'd0, rx_valid, underrun, frame_err}, 32'd0);
    Reset = 1'b1;
    rx0 = rx_cnt;
    oe0 = oe_cnt;
    for (int e = 0; e < 17; e++) begin
      SCLK = ~SCLK;
      wait_clk(H);
    end
    chk("mrst_quiet_oe", 32'(oe_cnt - oe0), 32'd0);
    chk("mrst_quiet_rx", 32'(rx_cnt - rx0), 32'd0);
    run_txn(2'd0, 1'b0, 1'b0, 8'h00, 1, {16'h0, 8'hE7}, 3'b000, '0, 1'b0);
    chk("mrst_miso", 32'(got_miso[0]), 32'hFF);
    chk("mrst_rx", 32'(rxq_at(rx_base)), 32'hE7);

    // Random transactions against a holding-register level model.
    for (int t = 0; t < 14; t++) begin
      rm   = 2'($urandom_range(0, 3));
      rinv = 1'($urandom_range(0, 1));
      rpre = 1'($urandom_range(0, 1));
      rpw  = 8'($urandom);
      rnf  = $urandom_range(1, 3);
      for (int k = 0; k < 3; k++) begin
        rmw[k] = 8'($urandom);
        rww[k] = 8'($urandom);
        rwr[k] = (k < rnf - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      run_txn(rm, rinv, rpre, rpw, rnf, rmw, rwr, rww, 1'b0);
      have = rpre;
      hw = rpw;
      exp_ur = 0;
      for (int k = 0; k < rnf; k++) begin
        exp_w = have ? hw : 8'hFF;
        if (!have) exp_ur++;
        chk($sformatf("rnd%0d_miso%0d", t, k), 32'(got_miso[k]), 32'(exp_w));
        chk($sformatf("rnd%0d_rx%0d", t, k), 32'(rxq_at(rx_base + k)), 32'(rmw[k]));
        have = rwr[k];
        hw = rww[k];
      end
      chk($sformatf("rnd%0d_rxn", t), 32'(rx_delta), 32'(rnf));
      chk($sformatf("rnd%0d_ur", t), 32'(ur_in), 32'(exp_ur));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_secondary.md
Name: spi_secondary

Overview:
- SPI secondary (slave) endpoint for the FPGA SPI primary: receives on MOSI, transmits on MISO, selected by one CS line of the primary's CS bus.
- Runs entirely on the local system clock; SCLK, CS and MOSI are oversampled, not used as clocks.
- Full-duplex, DATA_WIDTH bits per frame, MSB first.
- Multi-frame transactions are supported while CS stays asserted.

Parameters:
- DATA_WIDTH, 8, bits per frame.
- UNDERRUN_FILL, 8'hFF, word shifted out when no TX word is queued at frame start.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- spi_mode  input  2  [1]=CPOL, [0]=CPHA; sampled only while in IDLE.
- cs_inv_i  input  1  0: CS active-low; 1: CS active-high.
- CS  input  1  chip select from primary (asynchronous).
- SCLK  input  1  serial clock from primary (asynchronous).
- MOSI  input  1  serial data in (asynchronous).
- MISO  output  1  serial data out; value is 1'bz whenever miso_oe=0.
- miso_oe  output  1  1 while selected.
- tx_data  input  DATA_WIDTH  next word to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  TX holding register empty.
- rx_data  output  DATA_WIDTH  last complete received word.
- rx_valid  output  1  one-CLK pulse when rx_data updates.
- underrun  output  1  one-CLK pulse when UNDERRUN_FILL is loaded.
- frame_err  output  1  one-CLK pulse when CS deasserts mid-frame.

Behaviour:
- Reset (asynchronous, Reset=0) values:
  - MISO=z, miso_oe=0, tx_ready=1, rx_data=0.
  - rx_valid, underrun and frame_err all 0.
  - Synchronizers cleared; state=WAIT_IDLE.
- Input conditioning:
  - SCLK, CS and MOSI each pass through a 2-FF synchronizer.
  - Edges are detected from the 2nd vs 3rd flop.
  - Detected edge is visible 3 CLK after the pin toggles.
  - Required SCLK half-period: ≥4 CLK. Behaviour below that is undefined.
- sel = CS_sync XOR ~cs_inv_i, i.e. sel=1 when CS is in its active level.
- Leading edge = SCLK edge leaving the CPOL level; trailing edge = edge returning to CPOL.
- TX holding register (1 deep):
  - Accepts on tx_valid && tx_ready; tx_ready then goes 0 the next cycle.
  - Emptied (tx_ready=1) when its contents are moved into the shift register.
  - A write in the same cycle as a frame start is stored for the next frame. There is no bypass.
- FSM states:
  - WAIT_IDLE: entered after reset. Waits for sel=0 so that a reset released mid-transaction cannot latch a partial frame. Goes to IDLE.
  - IDLE: miso_oe=0. Latches spi_mode. On a sel rising edge, goes to LOAD.
  - LOAD (1 CLK): shift_reg ← holding if full, else UNDERRUN_FILL and pulse underrun. bit_cnt ← 0. miso_oe ← 1.
    - CPHA=0: MISO ← MSB in this cycle.
    - Goes to SHIFT.
  - SHIFT, CPHA=0: sample MOSI into rx_shift on leading edges; drive the next bit on trailing edges.
  - SHIFT, CPHA=1: drive the next bit on leading edges (the first leading edge drives MSB); sample on trailing edges.
  - SHIFT, end of frame: when the DATA_WIDTH-th sample is taken, rx_data ← assembled word and rx_valid pulses on the next CLK.
    - If sel is still 1, go to LOAD for the next frame. For CPHA=0 the MSB of the next frame is driven at that load, replacing the final trailing-edge shift.
  - Any state, sel falls:
    - miso_oe ← 0 and go to IDLE.
    - If bit_cnt is between 1 and DATA_WIDTH-1: discard the partial word, pulse frame_err, no rx_valid.
    - The shift register is not written back to the holding register.
- Latency:
  - MISO changes ≤4 CLK after the SCLK shift edge at the pin.
  - rx_valid asserts 4 CLK after the last sampling SCLK edge at the pin.
- SCLK edges while sel=0 are ignored.
- spi_mode and cs_inv_i changes mid-transaction have no effect until the next IDLE. cs_inv_i must be static while selected.

Decomposition:
- Package spi_pkg: spi_mode_t struct {cpol, cpha}; state enum {WAIT_IDLE, IDLE, LOAD, SHIFT}; default UNDERRUN_FILL.
- Sub-module spi_sync_edge: 2-FF synchronizer plus rise/fall detect. Instantiated for SCLK and CS; MOSI uses the synchronizer only.

Test Plan:
- Mode 0, cs_inv=0: preload tx 8'hA5; primary sends 8'h3C → MISO shows 10100101 MSB first; rx_data=8'h3C; exactly one rx_valid pulse; tx_ready returns to 1 at LOAD.
- Mode 3: preload 8'h5A; primary sends 8'hC8 → rx_data=8'hC8, MISO correct on leading edges. Repeat in modes 1 and 2, including CPOL=1 idle-high SCLK.
- Two-frame transaction, CS held: tx 8'h11 then 8'h22 written during frame 1 → MISO 11h then 22h; two rx_valid pulses.
- No TX written, primary sends 8'h02 → MISO=FF, underrun pulses once; rx_data=8'h02.
- CS deasserted after 5 SCLKs → frame_err pulse; no rx_valid; rx_data unchanged; miso_oe=0 and MISO=z within 4 CLK.
- Reset asserted mid-frame with CS held active → outputs take reset values; no activity until CS deasserts and reasserts; the following frame is received correctly. Also check cs_inv_i=1 selection.
